// File: rtl/fifo_pkg.sv
// Shared types and helpers for sync_fifo_lvl: width helper, pointer/level type macros, error-flag struct.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV
`define FIFO_PTR_T(AW) logic [(AW):0]
`define FIFO_LVL_T(AW) logic [(AW):0]

package fifo_pkg;

    function automatic int fifo_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage
`endif

// File: rtl/fifo_ram.sv
// Simple dual-port storage for sync_fifo_lvl: synchronous write, asynchronous read, no reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read data.
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    localparam int AW       = fifo_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_en,
    input  logic [WIDTH-1:0] w_data,
    output logic             full,
    output logic             almost_full,
    input  logic             r_en,
    output logic [WIDTH-1:0] r_data,
    output logic             empty,
    output logic             almost_empty,
    output logic [AW:0]      level,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam logic [AW:0] ONE      = 1;
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];
    localparam logic [AW:0] LVL_AF   = AF_THRESH[AW:0];
    localparam logic [AW:0] LVL_AE   = AE_THRESH[AW:0];

    `FIFO_PTR_T(AW) w_ptr, r_ptr;
    `FIFO_LVL_T(AW) level_q;
    fifo_err_t        err_q;
    logic             w_acc, r_acc;
    logic [WIDTH-1:0] ram_rdata;

    // Flags come only from the registered level, so no input-to-flag comb path.
    assign empty        = (level_q == '0);
    assign full         = (level_q == LVL_FULL);
    assign almost_full  = (level_q >= LVL_AF);
    assign almost_empty = (level_q <= LVL_AE);
    assign level        = level_q;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

    assign r_acc = r_en & ~empty;
    assign w_acc = w_en & (~full | r_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            level_q <= '0;
            err_q   <= '0;
        end else begin
            if (w_acc) w_ptr <= w_ptr + ONE;
            if (r_acc) r_ptr <= r_ptr + ONE;
            if (w_acc & ~r_acc)      level_q <= level_q + ONE;
            else if (r_acc & ~w_acc) level_q <= level_q - ONE;
            // a new error event wins over a same-cycle clear
            err_q.overflow  <= (w_en & ~w_acc) | (err_q.overflow  & ~clr_err);
            err_q.underflow <= (r_en & empty)  | (err_q.underflow & ~clr_err);
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_acc),
        .waddr (w_ptr[AW-1:0]),
        .wdata (w_data),
        .raddr (r_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign r_data = ram_rdata;
`else
    logic [WIDTH-1:0] r_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n)     r_data_q <= '0;
        else if (r_acc) r_data_q <= ram_rdata;
    end

    assign r_data = r_data_q;
`endif

endmodule
